// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   - state_t   : arbiter FSM states (IDLE, XFER)
//   - BURST_W   : width of the per-grant byte counter
//   - IDLE_W    : width of the owner-idle cycle counter
//   - PTR_W     : width of the round-robin pointer (covers up to 8 requesters)
//   - clog2()   : ceiling log2, minimum 1, for elaboration-time sizing
// ----------------------------------------------------------------------------
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int BURST_W = 8;
  localparam int IDLE_W  = 16;
  localparam int PTR_W   = 3;

  // Ceiling log2 with a floor of 1 so a 2-entry range still gets one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rr_select.sv
// ----------------------------------------------------------------------------
// uart_rr_select
// Purely combinational round-robin pick. Starting at ptr and walking upward
// with wrap-around, the first asserted request wins.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    search start index (always below NUM_REQ)
//   pick  out NUM_REQ  one-hot winner, all zero when nothing requests
//   valid out 1        at least one request is asserted
// ----------------------------------------------------------------------------
module uart_rr_select
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  // Candidate index for search step k is ptr + k, folded back below NUM_REQ.
  // Comparing the candidate against every position avoids indexing req with
  // a wider-than-needed index.
  logic [PTR_W:0] cand;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
        cand = cand - (PTR_W + 1)'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid && req[i] && (cand == (PTR_W + 1)'(i))) begin
          pick[i] = 1'b1;
          valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter byte port among NUM_REQ requesters. A grant is
// held for a whole packet (ended by the owner's LAST flag), but is forced off
// after MAX_BURST bytes or after IDLE_TIMEOUT cycles of the owner not
// presenting data, so no requester can starve the others.
//
// Handshake: a byte moves on any cycle where valid and ready are both high
// at the rising clock edge. A source holds data/last stable while valid is
// high and ready is low; valid is never withdrawn by the arbiter's datapath
// depending on ready (DIN_VLD has no path from DIN_RDY). REQ_RDY[i] is the
// owner's copy of DIN_RDY and is combinational from it.
//
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset
//   REQ_DATA         byte of requester i in bits [8*i+7:8*i]
//   REQ_VLD/REQ_LAST per-requester valid and end-of-packet flag
//   REQ_RDY          per-requester accept strobe (owner only)
//   DIN/DIN_VLD      byte and valid toward the UART transmitter
//   DIN_RDY          UART transmitter ready
//   GRANT            one-hot owner, zero when idle
//   BUSY             a grant is active
//   TIMEOUT_EVT      one-cycle pulse in the first IDLE cycle after a
//                    timeout release
//   DBG_STATE        FSM state (0 = IDLE, 1 = XFER)
//   DBG_RR_PTR       round-robin search start pointer
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_VLD,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_RDY,
  output logic [7:0]           DIN,
  output logic                 DIN_VLD,
  input  logic                 DIN_RDY,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic                 BUSY,
  output logic                 TIMEOUT_EVT,
  output logic                 DBG_STATE,
  output logic [PTR_W-1:0]     DBG_RR_PTR
);

  localparam int                 IDX_W      = clog2(NUM_REQ);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [PTR_W-1:0]   PTR_MAX    = PTR_W'(NUM_REQ - 1);

  // Reject parameter sets the counters and pointer cannot represent.
  if (NUM_REQ < 2 || IDX_W > PTR_W || MAX_BURST < 1 || MAX_BURST > 255 ||
      IDLE_TIMEOUT < 1 || IDLE_TIMEOUT > 65535) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of legal range");
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t               state;
  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     owner_idx;
  logic [PTR_W-1:0]     rr_ptr;
  logic [BURST_W-1:0]   burst_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic                 timeout_evt;

  // --------------------------------------------------------------------------
  // Arbitration pick
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] pick;
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;

  uart_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req   (REQ_VLD),
    .ptr   (rr_ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath, steered by the registered grant
  // --------------------------------------------------------------------------
  logic [7:0] owner_data;
  logic       owner_vld;
  logic       owner_last;
  logic       xfer;
  logic [PTR_W-1:0] next_ptr;

  // A zero grant leaves owner_data at 8'h00, so DIN is quiet while idle.
  always_comb begin
    owner_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner_data = REQ_DATA[8*i +: 8];
      end
    end
  end

  assign owner_vld  = |(REQ_VLD & grant);
  assign owner_last = |(REQ_LAST & grant);
  assign xfer       = owner_vld & DIN_RDY;
  assign next_ptr   = (owner_idx == PTR_MAX) ? '0 : owner_idx + 1'b1;

  // --------------------------------------------------------------------------
  // Arbiter FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      grant       <= '0;
      owner_idx   <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      idle_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant     <= pick;
            owner_idx <= pick_idx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            state     <= XFER;
          end
        end

        XFER: begin
          if (xfer) begin
            // A transfer wins over a timeout landing in the same cycle.
            burst_cnt <= burst_cnt + 1'b1;
            idle_cnt  <= '0;
            if (owner_last || (burst_cnt == BURST_LAST)) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end
          end else if (!owner_vld) begin
            if (idle_cnt == IDLE_LAST) begin
              grant       <= '0;
              rr_ptr      <= next_ptr;
              state       <= IDLE;
              timeout_evt <= 1'b1;
            end else if (idle_cnt != '1) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign REQ_RDY     = grant & {NUM_REQ{DIN_RDY}};
  assign DIN         = owner_data;
  assign DIN_VLD     = owner_vld;
  assign GRANT       = grant;
  assign BUSY        = (state == XFER);
  assign TIMEOUT_EVT = timeout_evt;
  assign DBG_STATE   = (state == XFER);
  assign DBG_RR_PTR  = rr_ptr;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter byte interface (DIN/DIN_VLD/DIN_RDY) among NUM_REQ requesters. Grants are held for a whole packet, delimited by a per-requester LAST flag. A burst limit and an idle timeout keep one requester from starving the others. Sits between the client logic (command responders, status reporters, debug taps) and the UART top-level transmit port.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MAX_BURST, 64, maximum bytes per grant before forced release; legal range 1..255.
- IDLE_TIMEOUT, 1024, cycles the granted requester may hold REQ_VLD low before forced release; legal range 1..65535.

Ports:
- CLK  in  1  system clock, single clock domain.
- RST_N  in  1  reset, asynchronous assert, active-low.
- REQ_DATA  in  8*NUM_REQ  byte from requester i, in bits [8*i+7:8*i].
- REQ_VLD  in  NUM_REQ  requester i has a byte on REQ_DATA.
- REQ_LAST  in  NUM_REQ  the current byte of requester i is the final byte of its packet.
- REQ_RDY  out  NUM_REQ  byte of requester i accepted this cycle.
- DIN  out  8  byte to the UART transmitter.
- DIN_VLD  out  1  byte valid to the UART transmitter.
- DIN_RDY  in  1  UART transmitter ready.
- GRANT  out  NUM_REQ  one-hot current owner; all zero when idle.
- BUSY  out  1  a grant is active.
- TIMEOUT_EVT  out  1  one-cycle pulse when a grant is released by the idle timeout.

## Operation
- States: IDLE, XFER.
- IDLE, with any REQ_VLD high:
  - Select the first requester with REQ_VLD high, searching from rr_ptr upward with modulo NUM_REQ wrap.
  - Register GRANT (one-hot), clear burst_cnt and idle_cnt, go to XFER.
- XFER, datapath (combinational from GRANT):
  - DIN = REQ_DATA of the owner.
  - DIN_VLD = REQ_VLD of the owner.
  - REQ_RDY[i] = GRANT[i] & DIN_RDY; all other REQ_RDY bits are 0.
- XFER, transfer: a byte transfers when DIN_VLD & DIN_RDY. On each transfer, burst_cnt increments and idle_cnt clears.
- XFER, release: the grant is released to IDLE when either of these holds:
  - a transfer occurs with the owner's REQ_LAST high;
  - a transfer occurs with burst_cnt == MAX_BURST-1.
- XFER, idle timeout:
  - While the owner's REQ_VLD is low, idle_cnt increments; it saturates and does not wrap.
  - When idle_cnt == IDLE_TIMEOUT-1 with REQ_VLD still low: release to IDLE and pulse TIMEOUT_EVT.
- On any release, rr_ptr is set to (owner index + 1) mod NUM_REQ, and GRANT clears.
- The REQ_VLD/REQ_LAST of non-owners are ignored in XFER; non-owners must hold their byte.
- DIN is 8'h00 whenever GRANT is all zero.
- Counter widths:
  - burst_cnt is 8 bits.
  - idle_cnt is 16 bits.
  - rr_ptr is 3 bits; it only takes values below NUM_REQ.

## Timing
- Reset values (RST_N low, asynchronous): state IDLE, GRANT 0, rr_ptr 0, burst_cnt 0, idle_cnt 0.
- Resulting outputs in reset: BUSY 0, DIN_VLD 0, DIN 0, REQ_RDY 0, TIMEOUT_EVT 0.
- Reset mid-packet aborts the grant immediately. The byte in flight is not guaranteed to be delivered.
- Grant latency: REQ_VLD rising in IDLE -> GRANT/BUSY high the next cycle. The first DIN_VLD appears in that same cycle.
- Release cycle: the last transfer occurs in cycle n, and GRANT is 0 in cycle n+1.
  - Arbitration happens in cycle n+1 (state IDLE), so the earliest new grant is in cycle n+2.
  - This gives exactly one bubble cycle between packets.
- LAST and burst limit in the same transfer: a single release, identical to the LAST-only case.
- Owner REQ_VLD rises in the timeout cycle: a transfer in that cycle takes precedence. There is no timeout and no TIMEOUT_EVT.
- IDLE_TIMEOUT=1: release on the first cycle the owner's VLD is low.
- TIMEOUT_EVT is registered. It is high only during the first IDLE cycle after a timeout release.
- No combinational path from DIN_RDY to DIN_VLD. There is a combinational path from DIN_RDY to REQ_RDY.

## Structure
- Shared package uart_arb_pkg holds:
  - the state enum (IDLE, XFER);
  - the width constants BURST_W=8, IDLE_W=16, PTR_W=3;
  - the clog2 helper.
- Sub-module uart_rr_select: purely combinational round-robin pick.
  - Inputs: request vector and rr_ptr.
  - Outputs: one-hot pick and valid.
  - Instantiated once; all registers stay in uart_tx_arbiter.

## Test plan
- Single packet: requester 1 sends 3 bytes 8'hA1,8'hA2,8'hA3 (LAST on third), DIN_RDY always 1.
  - Required: GRANT=4'b0010 for 3 cycles, DIN carries the bytes in order, GRANT=0 the next cycle, rr_ptr=2.
- Fairness: all 4 requesters hold VLD with 1-byte packets.
  - Required: grant order 0,1,2,3,0, with exactly one bubble cycle between grants.
- Burst limit: MAX_BURST=4, requester 2 streams 10 bytes with no LAST, requester 3 also waiting.
  - Required: release after byte 4, then a grant to requester 3, then requester 2 again.
- Backpressure: DIN_RDY toggles 1,0,0,1 during a packet.
  - Required: REQ_RDY of the owner mirrors DIN_RDY, DIN stays stable while stalled, no byte is lost or duplicated.
- Timeout: IDLE_TIMEOUT=8, owner drops VLD mid-packet.
  - Required: release after 8 low cycles, a one-cycle TIMEOUT_EVT pulse, and the next requester is granted.
  - Also: re-raising VLD at cycle 8 transfers the byte instead, with no pulse.
- Async reset mid-packet: RST_N low during XFER.
  - Required: GRANT, BUSY, DIN_VLD, REQ_RDY go to 0 without a clock edge, and arbitration restarts from requester 0.
